// File: rtl/elevator_pkg.sv
// ------------------------------------------------------------------
// elevator_pkg : shared state/direction types for the elevator engine
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package elevator_pkg;

  localparam int MAX_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    MOVING_UP   = 2'b01,
    MOVING_DOWN = 2'b10,
    DOORS_OPEN  = 2'b11
  } sim_state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

`default_nettype wire

// File: rtl/elevator_sim_fsm_if.sv
// ------------------------------------------------------------------
// elevator_sim_fsm_if : call/tick inputs and display-facing outputs
// Rev 1.0 -- estop member present only with ELEVATOR_ESTOP_EN
// ------------------------------------------------------------------
`default_nettype none

interface elevator_sim_fsm_if #(
  parameter int NUM_FLOORS = 8
);
  logic                  tick;
  logic [NUM_FLOORS-1:0] call_req;
  logic [1:0]            sim_state;
  logic [NUM_FLOORS-1:0] destination;
  logic [2:0]            current_floor;
`ifdef ELEVATOR_ESTOP_EN
  logic                  estop;
`endif

  modport master (
    output tick, call_req,
`ifdef ELEVATOR_ESTOP_EN
    output estop,
`endif
    input  sim_state, destination, current_floor
  );

  modport slave (
    input  tick, call_req,
`ifdef ELEVATOR_ESTOP_EN
    input  estop,
`endif
    output sim_state, destination, current_floor
  );
endinterface

`default_nettype wire

// File: rtl/elevator_dwell_timer.sv
// ------------------------------------------------------------------
// elevator_dwell_timer : tick counter, pulses done on the limit-th tick
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module elevator_dwell_timer #(
  parameter int TIMER_W = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               clear,
  input  wire logic               tick,
  input  wire logic [TIMER_W-1:0] limit,
  output logic                    done
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               at_limit;

  assign at_limit = (count_q == limit - 1'b1);
  assign done     = tick & ~clear & at_limit;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = at_limit ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/elevator_sim_fsm.sv
// ------------------------------------------------------------------
// elevator_sim_fsm : SCAN elevator engine feeding vgaController
// Rev 1.0 -- optional emergency stop via ELEVATOR_ESTOP_EN
// ------------------------------------------------------------------
`default_nettype none

module elevator_sim_fsm
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 6,
  parameter int TIMER_W     = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  elevator_sim_fsm_if.slave bus
);

  sim_state_t            state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] dest_q, dest_d;

  logic [NUM_FLOORS-1:0] floor_oh, above_mask, below_mask, clear_mask;
  logic                  above, below, here, next_up_pend, next_dn_pend;
  logic                  at_top, at_bottom, estop;
  logic                  timer_clear, timer_done;
  logic [TIMER_W-1:0]    timer_limit;

`ifdef ELEVATOR_ESTOP_EN
  assign estop = bus.estop;
`else
  assign estop = 1'b0;
`endif

  always_comb begin
    floor_oh   = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      floor_oh[i]   = (i == int'(floor_q));
      above_mask[i] = (i >  int'(floor_q));
      below_mask[i] = (i <  int'(floor_q));
    end
  end

  assign above        = |(dest_q & above_mask);
  assign below        = |(dest_q & below_mask);
  assign here         = |(dest_q & floor_oh);
  assign next_up_pend = |(dest_q & (floor_oh << 1));
  assign next_dn_pend = |(dest_q & (floor_oh >> 1));
  assign at_top       = (int'(floor_q) == NUM_FLOORS - 1);
  assign at_bottom    = (floor_q == '0);
  assign clear_mask   = (state_q == DOORS_OPEN) ? floor_oh : '0;

  // IDLE holds the timer at zero so every departure starts a fresh count.
  assign timer_clear = (state_q == IDLE) || estop;
  assign timer_limit = (state_q == DOORS_OPEN) ? TIMER_W'(DOOR_TICKS)
                                               : TIMER_W'(FLOOR_TICKS);

  elevator_dwell_timer #(
    .TIMER_W (TIMER_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .tick  (bus.tick),
    .limit (timer_limit),
    .done  (timer_done)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    dest_d  = (dest_q | bus.call_req) & ~clear_mask;

    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOORS_OPEN;
        end else if (above) begin
          state_d = MOVING_UP;
          dir_d   = UP;
        end else if (below) begin
          state_d = MOVING_DOWN;
          dir_d   = DOWN;
        end
      end
      // Stop decisions look at dest_q, so a call landing on the arrival clk is not served yet.
      MOVING_UP: begin
        if (timer_done) begin
          if (at_top) begin
            state_d = IDLE;
          end else begin
            floor_d = floor_q + 1'b1;
            if (next_up_pend) state_d = DOORS_OPEN;
          end
        end
      end
      MOVING_DOWN: begin
        if (timer_done) begin
          if (at_bottom) begin
            state_d = IDLE;
          end else begin
            floor_d = floor_q - 1'b1;
            if (next_dn_pend) state_d = DOORS_OPEN;
          end
        end
      end
      DOORS_OPEN: begin
        if (timer_done) begin
          state_d = IDLE;
          if (dir_q == UP && above) begin
            state_d = MOVING_UP;
          end else if (dir_q == DOWN && below) begin
            state_d = MOVING_DOWN;
          end else if (below) begin
            state_d = MOVING_DOWN;
            dir_d   = DOWN;
          end else if (above) begin
            state_d = MOVING_UP;
            dir_d   = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (estop) begin
      state_d = IDLE;
      dir_d   = dir_q;
      floor_d = floor_q;
      dest_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= UP;
      floor_q <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      dest_q  <= dest_d;
    end
  end

  assign bus.sim_state     = state_q;
  assign bus.destination   = dest_q;
  assign bus.current_floor = floor_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_sim_fsm.sv
// ------------------------------------------------------------------
// tb_elevator_sim_fsm : directed vector table plus random traffic vs model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_elevator_sim_fsm;

  localparam int NF = 8;
  localparam int FT = 4;
  localparam int DT = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_sim_fsm_if #(.NUM_FLOORS(NF)) bus();

  elevator_sim_fsm #(
    .NUM_FLOORS  (NF),
    .FLOOR_TICKS (FT),
    .DOOR_TICKS  (DT),
    .TIMER_W     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [1:0] es,
                       input logic [7:0] ed, input logic [2:0] ef);
    n_tests++;
    if (bus.sim_state !== es || bus.destination !== ed || bus.current_floor !== ef) begin
      n_fail++;
      $display("FAIL %s: got state=%b dest=%h floor=%0d, expected state=%b dest=%h floor=%0d",
               name, bus.sim_state, bus.destination, bus.current_floor, es, ed, ef);
    end
  endtask

  // Behavioural reference: elapsed-tick counters and a pending-floor set.
  int       m_mode;   // 0 idle, 1 up, 2 down, 3 doors
  int       m_floor;
  int       m_ticks;
  bit       m_going_up;
  bit [7:0] m_pend;

  function automatic void model_reset();
    m_mode = 0; m_floor = 0; m_ticks = 0; m_going_up = 1'b1; m_pend = '0;
  endfunction

  function automatic void model_step(input bit [7:0] call, input bit tk, input bit es);
    bit [7:0] pre;
    bit       any_above, any_below;
    int       target;
    pre       = m_pend;
    any_above = 1'b0;
    any_below = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (pre[f] && f > m_floor) any_above = 1'b1;
      if (pre[f] && f < m_floor) any_below = 1'b1;
    end
    if (es) begin
      m_mode = 0; m_ticks = 0; m_pend = '0;
      return;
    end
    m_pend = pre | call;
    if (m_mode == 3) m_pend[m_floor] = 1'b0;
    case (m_mode)
      0: begin
        m_ticks = 0;
        if (pre[m_floor])   m_mode = 3;
        else if (any_above) begin m_mode = 1; m_going_up = 1'b1; end
        else if (any_below) begin m_mode = 2; m_going_up = 1'b0; end
      end
      1, 2: if (tk) begin
        m_ticks++;
        if (m_ticks == FT) begin
          m_ticks = 0;
          target  = (m_mode == 1) ? m_floor + 1 : m_floor - 1;
          if (target < 0 || target >= NF) m_mode = 0;
          else begin
            m_floor = target;
            if (pre[m_floor]) m_mode = 3;
          end
        end
      end
      default: if (tk) begin
        m_ticks++;
        if (m_ticks == DT) begin
          m_ticks = 0;
          if (m_going_up && any_above)       m_mode = 1;
          else if (!m_going_up && any_below) m_mode = 2;
          else if (any_below) begin m_mode = 2; m_going_up = 1'b0; end
          else if (any_above) begin m_mode = 1; m_going_up = 1'b1; end
          else m_mode = 0;
        end
      end
    endcase
  endfunction

  typedef struct {
    logic [7:0] call;
    logic       tk;
    int         clks;
    logic [1:0] st;
    logic [7:0] dst;
    logic [2:0] fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] call, input logic tk, input int clks,
                              input logic [1:0] st, input logic [7:0] dst, input logic [2:0] fl);
    vec_t v;
    v.call = call; v.tk = tk; v.clks = clks; v.st = st; v.dst = dst; v.fl = fl;
    return v;
  endfunction

  task automatic step_clks(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      bus.call_req = '0;
    end
  endtask

  initial begin
    bus.tick     = 1'b0;
    bus.call_req = '0;
`ifdef ELEVATOR_ESTOP_EN
    bus.estop    = 1'b0;
`endif
    #1;
    check("reset_state", 2'b00, 8'h00, 3'd0);
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single call to floor 3
    vecs.push_back(mk(8'h08, 1'b1,  1, 2'b00, 8'h08, 3'd0));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b01, 8'h08, 3'd0));
    vecs.push_back(mk(8'h00, 1'b1,  4, 2'b01, 8'h08, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  8, 2'b11, 8'h08, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h00, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  4, 2'b11, 8'h00, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b00, 8'h00, 3'd3));
    // SCAN: going up at floor 3 with floors 6 and 1 pending
    vecs.push_back(mk(8'h40, 1'b1,  1, 2'b00, 8'h40, 3'd3));
    vecs.push_back(mk(8'h02, 1'b1,  1, 2'b01, 8'h42, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1, 11, 2'b01, 8'h42, 3'd5));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h42, 3'd6));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h02, 3'd6));
    vecs.push_back(mk(8'h00, 1'b1,  5, 2'b10, 8'h02, 3'd6));
    vecs.push_back(mk(8'h00, 1'b1, 20, 2'b11, 8'h02, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h00, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  5, 2'b00, 8'h00, 3'd1));
    // Tick gating mid-floor
    vecs.push_back(mk(8'h08, 1'b1,  1, 2'b00, 8'h08, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b01, 8'h08, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  2, 2'b01, 8'h08, 3'd1));
    vecs.push_back(mk(8'h00, 1'b0,100, 2'b01, 8'h08, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b01, 8'h08, 3'd1));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b01, 8'h08, 3'd2));
    vecs.push_back(mk(8'h00, 1'b1,  4, 2'b11, 8'h08, 3'd3));
    // Same-floor calls: absorbed while open, served from IDLE
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h00, 3'd3));
    vecs.push_back(mk(8'h08, 1'b1,  1, 2'b11, 8'h00, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  3, 2'b11, 8'h00, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b00, 8'h00, 3'd3));
    vecs.push_back(mk(8'h08, 1'b1,  1, 2'b00, 8'h08, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h08, 3'd3));
    vecs.push_back(mk(8'h00, 1'b1,  1, 2'b11, 8'h00, 3'd3));

    foreach (vecs[k]) begin
      bus.call_req = vecs[k].call;
      bus.tick     = vecs[k].tk;
      step_clks(vecs[k].clks);
      check($sformatf("vec%0d", k), vecs[k].st, vecs[k].dst, vecs[k].fl);
    end

    // Asynchronous reset while travelling with a busy request map
    bus.call_req = 8'hAA;
    step_clks(1);
    step_clks(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 2'b00, 8'h00, 3'd0);
    #4;
    @(posedge clk);
    #1;
    check("reset_hold", 2'b00, 8'h00, 3'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef ELEVATOR_ESTOP_EN
    bus.tick     = 1'b1;
    bus.call_req = 8'hF0;
    step_clks(1);
    check("estop_pre", 2'b00, 8'hF0, 3'd0);
    step_clks(5);
    check("estop_moving", 2'b01, 8'hF0, 3'd1);
    bus.estop    = 1'b1;
    bus.call_req = 8'h01;
    @(posedge clk);
    #1;
    check("estop_force", 2'b00, 8'h00, 3'd1);
    bus.call_req = 8'h81;
    @(posedge clk);
    #1;
    check("estop_ignore", 2'b00, 8'h00, 3'd1);
    bus.call_req = '0;
    bus.estop    = 1'b0;
    step_clks(2);
    check("estop_release", 2'b00, 8'h00, 3'd1);
`endif

    // Random traffic against the reference model
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      bit [7:0] rc;
      bit       rt;
      bit       re;
      rc = '0;
      if ($urandom_range(0, 11) == 0)      rc = 8'(1) << $urandom_range(0, 7);
      else if ($urandom_range(0, 59) == 0) rc = 8'($urandom);
      rt = ((cyc % 600) < 300) ? 1'b1 : ($urandom_range(0, 2) == 0);
      re = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
      re = ((cyc % 997) > 990);
      bus.estop = re;
`endif
      bus.call_req = rc;
      bus.tick     = rt;
      @(posedge clk);
      model_step(rc, rt, re);
      #1;
      check("random", m_mode[1:0], m_pend, m_floor[2:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
